// File: rtl/mole_display_driver.sv
// mole_display_driver
// Column-multiplexed scan driver for the 3x3 mole LED matrix. Cell i sits at
// row i/3, column i%3, the same indexing the keypad scanner uses. Patterns are
// double-buffered: a load fills the pending registers, and those move into the
// active registers only at a frame boundary, so a frame never shows two
// different patterns. Masked cells blink with a half-period of BLINK_FRAMES
// frames.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-low
//   load        single-cycle capture request for pattern/blink_mask
//   pattern     bit i lights cell i
//   blink_mask  bit i makes cell i blink (only where pattern bit is set)
//   busy        a pending pattern is waiting for the next frame boundary
//   column      active-low column strobe, at most one bit low
//   row         active-high row drive for the strobed column
//   frame_tick  one-cycle pulse after each completed frame
module mole_display_driver #(
    parameter logic [15:0] SCAN_DIV     = 16'd8333,
    parameter logic [3:0]  BLANK        = 4'd4,
    parameter logic [7:0]  BLINK_FRAMES = 8'd60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [8:0] pattern,
    input  logic [8:0] blink_mask,
    output logic       busy,
    output logic [2:0] column,
    output logic [2:0] row,
    output logic       frame_tick
);

    logic [15:0] prescaler;
    logic [1:0]  col;
    logic [7:0]  fcnt;
    logic        blink_phase;
    logic [8:0]  act_pat;
    logic [8:0]  act_mask;
    logic [8:0]  pend_pat;
    logic [8:0]  pend_mask;

    logic       tick;
    logic       boundary;
    logic       blanking;
    logic [8:0] visible;
    logic [2:0] drive_col;
    logic [2:0] drive_row;

    assign tick     = (prescaler == SCAN_DIV);
    assign boundary = tick && (col == 2'd2);
    // The first BLANK cycles of every slot stay dark so the previous column's
    // charge can bleed off before the next column is strobed.
    assign blanking = (prescaler < 16'(BLANK));
    assign visible  = act_pat & ~(act_mask & {9{blink_phase}});

    // Row r of the strobed column shows cell 3*r + col.
    always_comb begin
        drive_col = 3'b111;
        drive_row = 3'b000;
        case (col)
            2'd0: begin
                drive_col = 3'b110;
                drive_row = {visible[6], visible[3], visible[0]};
            end
            2'd1: begin
                drive_col = 3'b101;
                drive_row = {visible[7], visible[4], visible[1]};
            end
            2'd2: begin
                drive_col = 3'b011;
                drive_row = {visible[8], visible[5], visible[2]};
            end
            default: begin
                drive_col = 3'b111;
                drive_row = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler   <= '0;
            col         <= '0;
            fcnt        <= '0;
            blink_phase <= 1'b0;
            act_pat     <= '0;
            act_mask    <= '0;
            pend_pat    <= '0;
            pend_mask   <= '0;
            busy        <= 1'b0;
            column      <= 3'b111;
            row         <= 3'b000;
            frame_tick  <= 1'b0;
        end else begin
            if (tick) begin
                prescaler <= '0;
                col       <= (col == 2'd2) ? 2'd0 : col + 2'd1;
            end else begin
                prescaler <= prescaler + 16'd1;
            end

            if (boundary) begin
                if (fcnt == BLINK_FRAMES - 8'd1) begin
                    fcnt        <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    fcnt <= fcnt + 8'd1;
                end
            end

            // busy splits the two cases: while busy only the boundary swap can
            // act, while idle only a load can act. A load landing on a
            // boundary therefore waits a full frame before it is shown.
            if (busy) begin
                if (boundary) begin
                    act_pat  <= pend_pat;
                    act_mask <= pend_mask;
                    busy     <= 1'b0;
                end
            end else if (load) begin
                pend_pat  <= pattern;
                pend_mask <= blink_mask;
                busy      <= 1'b1;
            end

            frame_tick <= boundary;

            if (blanking) begin
                column <= 3'b111;
                row    <= 3'b000;
            end else begin
                column <= drive_col;
                row    <= drive_row;
            end
        end
    end

endmodule

// File: tb/tb_mole_display_driver.sv
module tb_mole_display_driver;

    localparam int SD    = 7;
    localparam int BL    = 2;
    localparam int BF    = 2;
    localparam int SLOT  = SD + 1;
    localparam int FRAME = 3 * SLOT;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [8:0] pattern;
    logic [8:0] blink_mask;
    logic       busy;
    logic [2:0] column;
    logic [2:0] row;
    logic       frame_tick;

    mole_display_driver #(
        .SCAN_DIV    (16'd7),
        .BLANK       (4'd2),
        .BLINK_FRAMES(8'd2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .pattern   (pattern),
        .blink_mask(blink_mask),
        .busy      (busy),
        .column    (column),
        .row       (row),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: time since reset release plus the two pattern buffers.
    // Scan position, frame number and blink phase all follow from t by division.
    int         t;
    logic       m_busy;
    logic [8:0] m_ppat, m_pmask, m_apat, m_amask;
    int         cyc_no  = 0;
    int         last_ft = -1;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc_no);
        end
    endtask

    task automatic model_reset();
        t       = 0;
        m_busy  = 1'b0;
        m_ppat  = '0;
        m_pmask = '0;
        m_apat  = '0;
        m_amask = '0;
        last_ft = -1;
    endtask

    // One clock: apply inputs, predict, clock, compare all outputs.
    task automatic step(input logic l, input logic [8:0] p, input logic [8:0] m);
        logic [2:0] e_col, e_row;
        logic       e_ft, e_busy, bnd;
        logic [8:0] vis;
        int         pp, c, fr, ph;
        load       = l;
        pattern    = p;
        blink_mask = m;
        if (!reset) begin
            e_col  = 3'b111;
            e_row  = 3'b000;
            e_ft   = 1'b0;
            e_busy = 1'b0;
        end else begin
            pp  = t % SLOT;
            c   = (t / SLOT) % 3;
            fr  = t / FRAME;
            ph  = (fr / BF) % 2;
            bnd = ((t % FRAME) == FRAME - 1);
            vis = m_apat & ~(m_amask & {9{ph[0]}});
            if (pp < BL) begin
                e_col = 3'b111;
                e_row = 3'b000;
            end else begin
                e_col = ~(3'b001 << c);
                for (int r = 0; r < 3; r++) e_row[r] = vis[3*r + c];
            end
            e_ft = bnd;
            if (m_busy) begin
                if (bnd) begin
                    m_apat  = m_ppat;
                    m_amask = m_pmask;
                    m_busy  = 1'b0;
                end
            end else if (l) begin
                m_ppat  = p;
                m_pmask = m;
                m_busy  = 1'b1;
            end
            e_busy = m_busy;
            t++;
        end
        @(posedge clk);
        #1;
        cyc_no++;
        chk("column", 9'(column), 9'(e_col));
        chk("row", 9'(row), 9'(e_row));
        chk("busy", 9'(busy), 9'(e_busy));
        chk("frame_tick", 9'(frame_tick), 9'(e_ft));
        if (frame_tick) begin
            if (last_ft >= 0) chk("ft_period", 9'(cyc_no - last_ft), 9'(FRAME));
            last_ft = cyc_no;
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 9'h000, 9'h000);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2 * FRAME && m_busy; i++) step(1'b0, 9'h000, 9'h000);
        chk("wait_idle", 9'(busy), 9'd0);
    endtask

    initial begin
        reset      = 1'b0;
        load       = 1'b0;
        pattern    = '0;
        blink_mask = '0;
        model_reset();
        @(negedge clk);

        // Reset held.
        idle(3);
        reset = 1'b1;

        // Center cell; first driven column appears on the 3rd edge after release.
        idle(3);
        step(1'b1, 9'b000010000, 9'h000);
        idle(2 * FRAME + 4);

        // Busy rejection.
        wait_idle();
        step(1'b1, 9'h1FF, 9'h000);
        step(1'b1, 9'h001, 9'h000);
        idle(2 * FRAME);

        // Blink of cell 0.
        wait_idle();
        step(1'b1, 9'h001, 9'h001);
        idle(7 * FRAME);

        // Load landing exactly on a frame boundary.
        wait_idle();
        for (int i = 0; i < FRAME && (t % FRAME) != FRAME - 1; i++) idle(1);
        step(1'b1, 9'h155, 9'h0F0);
        idle(2 * FRAME + 2);

        // Random loads at random times.
        for (int i = 0; i < 40 * FRAME; i++)
            step(($urandom_range(0, 9) == 0), 9'($urandom), 9'($urandom));

        // Reset in the middle of the col=1 slot while a load is pending.
        wait_idle();
        for (int i = 0; i < FRAME && (t % FRAME) != 4; i++) idle(1);
        step(1'b1, 9'h1AB, 9'h022);
        for (int i = 0; i < FRAME && (t % FRAME) != 12; i++) idle(1);
        chk("busy_pre_reset", 9'(busy), 9'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_column", 9'(column), 9'(3'b111));
        chk("rst_row", 9'(row), 9'd0);
        chk("rst_busy", 9'(busy), 9'd0);
        chk("rst_frame_tick", 9'(frame_tick), 9'd0);
        model_reset();
        @(negedge clk);
        idle(2);
        reset = 1'b1;
        idle(2 * FRAME);
        step(1'b1, 9'h0AA, 9'h000);
        idle(2 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
